mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_accumulator_mult.sv | 31 +++
 rtl/mac_accumulator.sv | 118 +++++++++++
 tb/tb_mac_accumulator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the multiply-accumulate block
package mac_pkg;

    localparam int MAC_ACC_W = 40;
    localparam int MAC_LEN_W = 8;
    localparam int PROD_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mac_accumulator_mult.sv
// rtl/mac_accumulator_mult.sv - 16x16 unsigned combinational multiplier, carry-save reduction
module mac_accumulator_mult
    import mac_pkg::*;
(
    input  logic [15:0]       a,
    input  logic [15:0]       b,
    output logic [PROD_W-1:0] prod
);

    logic [PROD_W-1:0] sum_v;
    logic [PROD_W-1:0] car_v;
    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] maj;

    // Partial products are folded through 3:2 compressors; one carry-propagate add at the end.
    always_comb begin
        sum_v = '0;
        car_v = '0;
        pp    = '0;
        maj   = '0;
        for (int i = 0; i < 16; i++) begin
            pp    = b[i] ? (PROD_W'(a) << i) : '0;
            maj   = (sum_v & car_v) | (sum_v & pp) | (car_v & pp);
            sum_v = sum_v ^ car_v ^ pp;
            car_v = maj << 1;
        end
    end

    assign prod = sum_v + car_v;

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - streaming sum-of-products with three-stage pipeline and sticky overflow
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W,
    parameter int LEN_W = MAC_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ACCUM = ST_ACCUM;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] OUT   = ST_OUT;

    logic [1:0]        state;
    logic [LEN_W-1:0]  remaining;
    logic              s1_valid;
    logic [15:0]       s1_a;
    logic [15:0]       s1_b;
    logic              s2_valid;
    logic [PROD_W-1:0] s2_prod;
    logic [PROD_W-1:0] mult_prod;
    logic [ACC_W-1:0]  acc;
    logic              ovf;
    logic [ACC_W:0]    sum_ext;
    logic              in_fire;
    logic              out_fire;

    mac_accumulator_mult u_mult (
        .a    (s1_a),
        .b    (s1_b),
        .prod (mult_prod)
    );

    assign in_ready  = (state == ACCUM) && (remaining != '0);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign out_sum   = out_valid ? acc : '0;
    assign out_ovf   = out_valid && ovf;
    assign sum_ext   = {1'b0, acc} + (ACC_W+1)'(s2_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        state     <= (len != '0) ? ACCUM : OUT;
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) state <= OUT;
                end
                OUT: begin
                    if (out_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            s2_prod  <= '0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_a <= in_a;
                s1_b <= in_b;
            end
            s2_valid <= s1_valid;
            if (s1_valid) s2_prod <= mult_prod;
        end
    end

    // A zero-length run also takes the clearing branch, so its result reads as 0 with no overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if ((state == IDLE) && start) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (s2_valid) begin
            acc <= sum_ext[ACC_W-1:0];
            ovf <= ovf | sum_ext[ACC_W];
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized self-checking bench for mac_accumulator (40-bit and 32-bit)
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [39:0] out_sum;
    logic        n_in_ready, n_out_valid, n_out_ovf, n_busy;
    logic [31:0] n_out_sum;

    int checks = 0;
    int errors = 0;
    logic [15:0] term_a[$];
    logic [15:0] term_b[$];

    always #5 clk = ~clk;

    mac_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .busy(busy)
    );

    mac_accumulator #(.ACC_W(32), .LEN_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_sum(n_out_sum),
        .out_ovf(n_out_ovf), .busy(n_busy)
    );

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({out_valid, out_sum, out_ovf, in_ready, busy} !== 44'd0) begin
            errors++;
            $display("FAIL %s outputs40: got v=%0b sum=%0h ovf=%0b rdy=%0b busy=%0b required all 0",
                     tag, out_valid, out_sum, out_ovf, in_ready, busy);
        end
        checks++;
        if ({n_out_valid, n_out_sum, n_out_ovf, n_in_ready, n_busy} !== 36'd0) begin
            errors++;
            $display("FAIL %s outputs32: got v=%0b sum=%0h ovf=%0b rdy=%0b busy=%0b required all 0",
                     tag, n_out_valid, n_out_sum, n_out_ovf, n_in_ready, n_busy);
        end
    endtask

    // Runs the terms queued in term_a/term_b and checks both instances against plain arithmetic.
    task automatic run_terms(input string tag, input int gap_pct, input int hold, input bit poke_start);
        int n = term_a.size();
        int idx = 0;
        int cyc = 0;
        int lat = 0;
        bit hs;
        longint unsigned total = 0;
        for (int i = 0; i < n; i++) total += 64'(term_a[i]) * 64'(term_b[i]);

        start = 1'b1; len = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && cyc < 1000) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom);
            end else begin
                in_valid = 1'b1; in_a = term_a[idx]; in_b = term_b[idx];
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) idx++;
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s terms_taken: got %0d required %0d", tag, idx, n);
        end
        // Operands offered after the last term must be ignored.
        in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_drop: got %0b required 0", tag, in_ready);
        end
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required 3", tag, lat);
        end
        checks++;
        if (out_sum !== total[39:0] || out_ovf !== ((total >> 40) != 0)) begin
            errors++;
            $display("FAIL %s result40: got %0h/%0b required %0h/%0b", tag, out_sum, out_ovf,
                     total[39:0], (total >> 40) != 0);
        end
        checks++;
        if (n_out_valid !== 1'b1 || n_out_sum !== total[31:0] || n_out_ovf !== ((total >> 32) != 0)) begin
            errors++;
            $display("FAIL %s result32: got v=%0b %0h/%0b required 1 %0h/%0b", tag, n_out_valid,
                     n_out_sum, n_out_ovf, total[31:0], (total >> 32) != 0);
        end
        for (int k = 0; k < hold; k++) begin
            start = poke_start && (k == 1);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_sum !== total[39:0]) begin
                errors++;
                $display("FAIL %s hold%0d: got v=%0b sum=%0h required 1 %0h", tag, k, out_valid,
                         out_sum, total[39:0]);
            end
        end
        out_ready = 1'b1; start = poke_start;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got busy=%0b v=%0b required 0 0", tag, busy, out_valid);
        end
        if (poke_start) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s no_new_run: got busy=%0b rdy=%0b required 0 0", tag, busy, in_ready);
            end
        end
        term_a.delete();
        term_b.delete();
    endtask

    task automatic test_reset();
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");
    endtask

    task automatic test_single();
        term_a.push_back(16'd3); term_b.push_back(16'd5);
        run_terms("single", 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            term_a.push_back(16'hFFFF); term_b.push_back(16'hFFFF);
        end
        run_terms("b2b_ffff", 0, 0, 1'b0);
    endtask

    task automatic test_len_zero();
        bit rdy_seen = 1'b0;
        start = 1'b1; len = 8'd0;
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        rdy_seen = rdy_seen | in_ready;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 40'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL len0_result: got v=%0b sum=%0h ovf=%0b required 1 0 0", out_valid, out_sum, out_ovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        rdy_seen = rdy_seen | in_ready;
        checks++;
        if (busy !== 1'b0 || rdy_seen) begin
            errors++;
            $display("FAIL len0_done: got busy=%0b ready_seen=%0b required 0 0", busy, rdy_seen);
        end
    endtask

    task automatic test_wrap32();
        for (int i = 0; i < 2; i++) begin
            term_a.push_back(16'hFFFF); term_b.push_back(16'hFFFF);
        end
        run_terms("wrap32", 0, 0, 1'b0);
    endtask

    task automatic test_hold_start();
        for (int i = 0; i < 3; i++) begin
            term_a.push_back(16'($urandom)); term_b.push_back(16'($urandom));
        end
        run_terms("hold_start", 0, 5, 1'b1);
    endtask

    task automatic test_reset_midrun();
        int taken = 0;
        int cyc = 0;
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h1357;
        while (taken < 2 && cyc < 20) begin
            if (in_ready) taken++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        term_a.push_back(16'd2); term_b.push_back(16'd7);
        run_terms("after_reset", 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            int n = int'($urandom_range(12, 1));
            bit big = ($urandom_range(3) == 0);
            for (int i = 0; i < n; i++) begin
                term_a.push_back(big ? 16'hFFFF - 16'($urandom_range(15)) : 16'($urandom));
                term_b.push_back(big ? 16'hFFFF - 16'($urandom_range(15)) : 16'($urandom));
            end
            run_terms($sformatf("random%0d", r), 30, int'($urandom_range(3)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_len_zero();
        test_wrap32();
        test_hold_start();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
